// File: rtl/mem_access_unit_if.sv
// Core-side load/store handshake plus the word-wide RAM port, bundled for mem_access_unit.
// The slave modport is the unit's view; master is the core/RAM side.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              op_we;
    logic [1:0]        op_size;
    logic              op_signed;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic [31:0]       rdata;
    logic              misaligned;
    logic [ADDR_W-1:0] sa;
    logic [31:0]       sin;
    logic              sw;
    logic [31:0]       sout;

    modport slave (
        input  req, op_we, op_size, op_signed, addr, wdata, sout,
        output busy, done, rdata, misaligned, sa, sin, sw
    );

    modport master (
        output req, op_we, op_size, op_signed, addr, wdata, sout,
        input  busy, done, rdata, misaligned, sa, sin, sw
    );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store engine on a word-wide RAM, with read-modify-write for sub-word stores.
// Define MAU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of performing them.
module mem_access_unit #(
    parameter int ADDR_W     = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input logic                clk,
    input logic                rst,
    mem_access_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] sa_q, sa_d;
    logic [31:0]       sin_q, sin_d;
    logic              done_q, done_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              mis_q, mis_d;

    logic [1:0]        req_size;
    logic              trap;
    logic [4:0]        shift_amt;
    logic [31:0]       shifted;
    logic [31:0]       lane_mask;
    logic [31:0]       load_val;
    logic [31:0]       merged;

    assign req_size = (bus.op_size == 2'b11) ? SZ_WORD : bus.op_size;

`ifdef MAU_MISALIGN_TRAP_EN
    assign trap = ((req_size == SZ_HALF) && bus.addr[0]) ||
                  ((req_size == SZ_WORD) && (bus.addr[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    // Bit position of the addressed lane's LSB within the RAM word.
    always_comb begin
        shift_amt = 5'd0;
        case (size_q)
            SZ_BYTE: shift_amt = BIG_ENDIAN ? {~off_q, 3'b000} : {off_q, 3'b000};
            SZ_HALF: shift_amt = BIG_ENDIAN ? {~off_q[1], 4'b0000} : {off_q[1], 4'b0000};
            default: shift_amt = 5'd0;
        endcase
    end

    always_comb begin
        shifted   = bus.sout >> shift_amt;
        lane_mask = 32'hFFFF_FFFF;
        load_val  = shifted;
        case (size_q)
            SZ_BYTE: begin
                lane_mask = 32'h0000_00FF << shift_amt;
                load_val  = {{24{signed_q & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                lane_mask = 32'h0000_FFFF << shift_amt;
                load_val  = {{16{signed_q & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                lane_mask = 32'hFFFF_FFFF;
                load_val  = shifted;
            end
        endcase
        merged = (bus.sout & ~lane_mask) | ((wdata_q << shift_amt) & lane_mask);
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        off_d    = off_q;
        wdata_d  = wdata_q;
        sa_d     = sa_q;
        sin_d    = sin_q;
        done_d   = 1'b0;
        rdata_d  = rdata_q;
        mis_d    = mis_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    we_d     = bus.op_we;
                    size_d   = req_size;
                    signed_d = bus.op_signed;
                    off_d    = bus.addr[1:0];
                    wdata_d  = bus.wdata;
                    if (trap) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        mis_d   = 1'b1;
                    end else begin
                        sa_d = {bus.addr[ADDR_W-1:2], 2'b00};
                        if (bus.op_we && (req_size == SZ_WORD)) begin
                            sin_d   = bus.wdata;
                            state_d = WRITE;
                        end else begin
                            state_d = READ;
                        end
                    end
                end
            end
            READ: begin
                if (we_q) begin
                    sin_d   = merged;
                    state_d = WRITE;
                end else begin
                    rdata_d = load_val;
                    mis_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            WRITE: begin
                mis_d   = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            off_q    <= 2'b00;
            wdata_q  <= 32'h0;
            sa_q     <= '0;
            sin_q    <= 32'h0;
            done_q   <= 1'b0;
            rdata_q  <= 32'h0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            off_q    <= off_d;
            wdata_q  <= wdata_d;
            sa_q     <= sa_d;
            sin_q    <= sin_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            mis_q    <= mis_d;
        end
    end

    // A reset landing in the WRITE cycle must block the RAM write on that same edge.
    assign bus.sw         = (state_q == WRITE) && !rst;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.rdata      = rdata_q;
    assign bus.misaligned = mis_q;
    assign bus.sa         = sa_q;
    assign bus.sin        = sin_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed loads/stores against a 16-word RAM model,
// with expected responses queued at issue and checked by a done-driven monitor.
module tb_mem_access_unit;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          cyc;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        mem_init;
    logic [31:0] mem [16];
    int          cyc;
    int          checks;
    int          errors;
    int          sw_count;
    int          last_sw_cyc;
    exp_t        sb_q[$];

    mem_access_unit_if #(.ADDR_W(32)) intf ();

    mem_access_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (intf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter; the value read just after edge N is N.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Word-wide RAM: combinational read, write on posedge when sw is high.
    assign intf.sout = mem[intf.sa[5:2]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[3] <= 32'hFFFF_FFF9;
        end else if (intf.sw) begin
            mem[intf.sa[5:2]] <= intf.sin;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: counts RAM writes and checks every done pulse against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (intf.sw) begin
            sw_count++;
            last_sw_cyc = cyc + 1;
        end
        if (!rst && intf.done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1 rdata=0x%08h expected no done", intf.rdata);
            end else begin
                e = sb_q.pop_front();
                checkOutput({e.name, "_rdata"}, intf.rdata, e.rdata);
                checkOutput({e.name, "_mis"}, {31'b0, intf.misaligned}, {31'b0, e.mis});
                checkOutput({e.name, "_donecyc"}, cyc + 1, e.cyc);
            end
        end
    end

    task automatic waitIdle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (!intf.busy) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got busy=1 after 50 cycles expected idle", name);
        end
    endtask

    task automatic applyStimulus(input string name, input logic we, input logic [1:0] size,
                                 input logic sgn, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] exp_rd, input logic exp_mis,
                                 input int done_lat, input int exp_sw, input int sw_lat);
        int n;
        int sw0;
        waitIdle(name);
        intf.op_we     = we;
        intf.op_size   = size;
        intf.op_signed = sgn;
        intf.addr      = a;
        intf.wdata     = wd;
        intf.req       = 1'b1;
        sw0 = sw_count;
        @(posedge clk);
        #1;
        intf.req = 1'b0;
        n = cyc;
        sb_q.push_back('{rdata: exp_rd, mis: exp_mis, cyc: n + done_lat, name: name});
        waitIdle(name);
        checkOutput({name, "_swcount"}, sw_count - sw0, exp_sw);
        if (exp_sw == 1) checkOutput({name, "_swcyc"}, last_sw_cyc, n + sw_lat);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int sw0;
        checks         = 0;
        errors         = 0;
        sw_count       = 0;
        last_sw_cyc    = 0;
        rst            = 1'b1;
        mem_init       = 1'b1;
        intf.req       = 1'b0;
        intf.op_we     = 1'b0;
        intf.op_size   = 2'b00;
        intf.op_signed = 1'b0;
        intf.addr      = 32'h0;
        intf.wdata     = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_init = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", {31'b0, intf.busy}, 32'h0);
        checkOutput("rst_done", {31'b0, intf.done}, 32'h0);
        checkOutput("rst_rdata", intf.rdata, 32'h0);
        checkOutput("rst_mis", {31'b0, intf.misaligned}, 32'h0);
        checkOutput("rst_sa", intf.sa, 32'h0);
        checkOutput("rst_sin", intf.sin, 32'h0);
        checkOutput("rst_sw", {31'b0, intf.sw}, 32'h0);

        // name, we, size, signed, addr, wdata, exp rdata, exp mis, done lat, sw count, sw lat
        applyStimulus("lb_s15",   0, 2'b00, 1, 32'd15, 32'h0, 32'hFFFF_FFF9, 0, 2, 0, 0);
        applyStimulus("lbu15",    0, 2'b00, 0, 32'd15, 32'h0, 32'h0000_00F9, 0, 2, 0, 0);
        applyStimulus("lh_s12",   0, 2'b01, 1, 32'd12, 32'h0, 32'hFFFF_FFFF, 0, 2, 0, 0);
        applyStimulus("lhu14",    0, 2'b01, 0, 32'd14, 32'h0, 32'h0000_FFF9, 0, 2, 0, 0);
`ifdef MAU_MISALIGN_TRAP_EN
        applyStimulus("lh_mis13", 0, 2'b01, 1, 32'd13, 32'h0, 32'h0000_FFF9, 1, 1, 0, 0);
`else
        applyStimulus("lh_mis13", 0, 2'b01, 1, 32'd13, 32'h0, 32'hFFFF_FFFF, 0, 2, 0, 0);
`endif
        applyStimulus("lbu12",    0, 2'b00, 0, 32'd12, 32'h0, 32'h0000_00FF, 0, 2, 0, 0);
        applyStimulus("sb13",     1, 2'b00, 0, 32'd13, 32'h45, 32'h0000_00FF, 0, 3, 1, 2);
        applyStimulus("lw12_a",   0, 2'b10, 0, 32'd12, 32'h0, 32'hFF45_FFF9, 0, 2, 0, 0);
        applyStimulus("sw12",     1, 2'b10, 0, 32'd12, 32'd69, 32'hFF45_FFF9, 0, 2, 1, 1);
        applyStimulus("lw12_sz3", 0, 2'b11, 0, 32'd12, 32'h0, 32'h0000_0045, 0, 2, 0, 0);
        applyStimulus("sh14",     1, 2'b01, 0, 32'd14, 32'h1234_BEEF, 32'h0000_0045, 0, 3, 1, 2);
        applyStimulus("lh_s14",   0, 2'b01, 1, 32'd14, 32'h0, 32'hFFFF_BEEF, 0, 2, 0, 0);
        applyStimulus("lb_s15b",  0, 2'b00, 1, 32'd15, 32'h0, 32'hFFFF_FFEF, 0, 2, 0, 0);

        // Reset during the WRITE cycle of a word store must cancel the write.
        waitIdle("rstmid");
        intf.op_we   = 1'b1;
        intf.op_size = 2'b10;
        intf.addr    = 32'd12;
        intf.wdata   = 32'h0;
        intf.req     = 1'b1;
        sw0 = sw_count;
        @(posedge clk);
        #1;
        intf.req = 1'b0;
        checkOutput("rstmid_sw_before", {31'b0, intf.sw}, 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("rstmid_sw_gated", {31'b0, intf.sw}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstmid_busy", {31'b0, intf.busy}, 32'h0);
        checkOutput("rstmid_done", {31'b0, intf.done}, 32'h0);
        checkOutput("rstmid_rdata", intf.rdata, 32'h0);
        checkOutput("rstmid_swcount", sw_count - sw0, 32'h0);
        applyStimulus("lw12_b",   0, 2'b10, 0, 32'd12, 32'h0, 32'h0000_BEEF, 0, 2, 0, 0);

        // A store request raised while busy must be ignored.
        waitIdle("busyreq");
        intf.op_we   = 1'b0;
        intf.op_size = 2'b10;
        intf.addr    = 32'd12;
        intf.req     = 1'b1;
        sw0 = sw_count;
        @(posedge clk);
        #1;
        intf.req = 1'b0;
        n = cyc;
        sb_q.push_back('{rdata: 32'h0000_BEEF, mis: 1'b0, cyc: n + 2, name: "busyreq"});
        @(negedge clk);
        intf.op_we   = 1'b1;
        intf.wdata   = 32'hDEAD_BEEF;
        intf.req     = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        intf.req = 1'b0;
        waitIdle("busyreq");
        repeat (3) @(negedge clk);
        checkOutput("busyreq_swcount", sw_count - sw0, 32'h0);
        checkOutput("busyreq_idle", {31'b0, intf.busy}, 32'h0);
        applyStimulus("lw12_c",   0, 2'b10, 0, 32'd12, 32'h0, 32'h0000_BEEF, 0, 2, 0, 0);

        repeat (5) @(negedge clk);
        checkOutput("sb_empty", sb_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
